// File: rtl/maxpool_window_gen_if.sv
// Stream-in / window-out bundle for maxpool_window_gen.
// MAXPOOL_WINGEN_FRAME_DONE_EN adds the o_frame_done strobe.
interface maxpool_window_gen_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] o_data_0;
    logic [DATA_WIDTH-1:0] o_data_1;
    logic [DATA_WIDTH-1:0] o_data_2;
    logic [DATA_WIDTH-1:0] o_data_3;
    logic                  o_valid;
`ifdef MAXPOOL_WINGEN_FRAME_DONE_EN
    logic                  o_frame_done;

    modport master (
        output i_data, i_valid,
        input  o_data_0, o_data_1, o_data_2, o_data_3, o_valid, o_frame_done
    );
    modport slave (
        input  i_data, i_valid,
        output o_data_0, o_data_1, o_data_2, o_data_3, o_valid, o_frame_done
    );
`else
    modport master (
        output i_data, i_valid,
        input  o_data_0, o_data_1, o_data_2, o_data_3, o_valid
    );
    modport slave (
        input  i_data, i_valid,
        output o_data_0, o_data_1, o_data_2, o_data_3, o_valid
    );
`endif
endinterface

// File: rtl/maxpool_window_gen.sv
// 2x2 stride-2 pooling window generator: buffers one even row, emits a window on each odd-row/odd-col pixel.
// Optional MAXPOOL_WINGEN_FRAME_DONE_EN adds a last-window-of-frame strobe.
module maxpool_window_gen #(
    parameter int DATA_WIDTH   = 32,
    parameter int IMAGE_WIDTH  = 224,
    parameter int IMAGE_HEIGHT = 224
) (
    input  logic                  clk,
    input  logic                  rst_n,
    maxpool_window_gen_if.slave   bus
);
    localparam int COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [DATA_WIDTH-1:0] line_buf [IMAGE_WIDTH];
    logic [DATA_WIDTH-1:0] top_left;
    logic [DATA_WIDTH-1:0] bot_left;
    logic [DATA_WIDTH-1:0] data_0, data_1, data_2, data_3;
    logic                  valid_q;
    logic                  last_col;
    logic                  last_row;

    assign last_col = (col == COL_W'(IMAGE_WIDTH - 1));
    assign last_row = (row == ROW_W'(IMAGE_HEIGHT - 1));

    // Line buffer is deliberately unreset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (bus.i_valid && !row[0]) begin
            line_buf[col] <= bus.i_data;
        end
    end

`ifdef MAXPOOL_WINGEN_FRAME_DONE_EN
    logic frame_done_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            top_left <= '0;
            bot_left <= '0;
            data_0   <= '0;
            data_1   <= '0;
            data_2   <= '0;
            data_3   <= '0;
            valid_q  <= 1'b0;
`ifdef MAXPOOL_WINGEN_FRAME_DONE_EN
            frame_done_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
`ifdef MAXPOOL_WINGEN_FRAME_DONE_EN
            frame_done_q <= 1'b0;
`endif
            if (bus.i_valid) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                // Odd rows pair each new pixel with the buffered pixel above it.
                if (row[0]) begin
                    if (!col[0]) begin
                        top_left <= line_buf[col];
                        bot_left <= bus.i_data;
                    end else begin
                        data_0  <= top_left;
                        data_1  <= line_buf[col];
                        data_2  <= bot_left;
                        data_3  <= bus.i_data;
                        valid_q <= 1'b1;
`ifdef MAXPOOL_WINGEN_FRAME_DONE_EN
                        frame_done_q <= last_col && last_row;
`endif
                    end
                end
            end
        end
    end

    assign bus.o_data_0 = data_0;
    assign bus.o_data_1 = data_1;
    assign bus.o_data_2 = data_2;
    assign bus.o_data_3 = data_3;
    assign bus.o_valid  = valid_q;
`ifdef MAXPOOL_WINGEN_FRAME_DONE_EN
    assign bus.o_frame_done = frame_done_q;
`endif

endmodule
